// File: rtl/rob.sv
// 2-wide in-order reorder buffer feeding RAT/RRAT retirement; retire/flush are combinational from state.
// Dispatch is gated by dispatch_ok (current count only); completion is always accepted; retire never stalls.
module rob #(
    parameter int ROB_SZ  = 32,
    parameter int ROB_IDX = 5,
    parameter int SCALAR  = 2,
    parameter int RAT_IDX = 5,
    parameter int PRF_IDX = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [SCALAR-1:0]          issue,
    input  logic [SCALAR*RAT_IDX-1:0]  dest_idx_in,
    input  logic [SCALAR*PRF_IDX-1:0]  pdest_idx_in,
    output logic [SCALAR*ROB_IDX-1:0]  rob_idx_out,
    output logic [SCALAR-1:0]          dispatch_ok,
    input  logic [SCALAR-1:0]          complete,
    input  logic [SCALAR*ROB_IDX-1:0]  complete_rob_idx,
    input  logic [SCALAR-1:0]          complete_mispred,
    output logic [SCALAR-1:0]          retire,
    output logic [SCALAR*RAT_IDX-1:0]  retire_dest_idx_out,
    output logic [SCALAR*PRF_IDX-1:0]  retire_pdest_idx_out,
    output logic                       flush,
    output logic                       empty
);

    typedef struct packed {
        logic               valid;
        logic               done;
        logic               mispred;
        logic [RAT_IDX-1:0] dest;
        logic [PRF_IDX-1:0] pdest;
    } rob_entry_t;

    localparam logic [ROB_IDX:0] CNT_FULL  = (ROB_IDX+1)'(ROB_SZ);
    localparam logic [ROB_IDX:0] CNT_FULL1 = (ROB_IDX+1)'(ROB_SZ - 1);

    rob_entry_t         ent_q [ROB_SZ];
    logic [ROB_IDX-1:0] head_q;
    logic [ROB_IDX-1:0] tail_q;
    logic [ROB_IDX:0]   count_q;

    logic [ROB_IDX-1:0] head_nx1;
    logic [ROB_IDX-1:0] tail_w1;
    logic [1:0]         disp;
    logic [1:0]         ret;
    logic [1:0]         n_disp;
    logic [1:0]         n_ret;
    logic [ROB_SZ-1:0]  alloc0;
    logic [ROB_SZ-1:0]  alloc1;
    logic [ROB_SZ-1:0]  free_v;
    logic [ROB_SZ-1:0]  done_set;
    logic [ROB_SZ-1:0]  mp_set;

    always_comb begin
        head_nx1    = head_q + 1'b1;
        tail_w1     = tail_q + ROB_IDX'(issue[0]);
        rob_idx_out = {tail_w1, tail_q};

        dispatch_ok[0] = (count_q < CNT_FULL);
        dispatch_ok[1] = (count_q < CNT_FULL1);
        empty          = (count_q == '0);

        // way1 may only retire behind a non-mispredicted head, so a flush never skips an older entry
        ret[0] = (count_q != '0) && ent_q[head_q].done;
        ret[1] = ret[0] && !ent_q[head_q].mispred && (count_q >= (ROB_IDX+1)'(2))
                 && ent_q[head_nx1].done;
        flush  = (ret[0] && ent_q[head_q].mispred) || (ret[1] && ent_q[head_nx1].mispred);
        retire = ret;

        retire_dest_idx_out  = '0;
        retire_pdest_idx_out = '0;
        if (ret[0]) begin
            retire_dest_idx_out[0 +: RAT_IDX]  = ent_q[head_q].dest;
            retire_pdest_idx_out[0 +: PRF_IDX] = ent_q[head_q].pdest;
        end
        if (ret[1]) begin
            retire_dest_idx_out[RAT_IDX +: RAT_IDX]  = ent_q[head_nx1].dest;
            retire_pdest_idx_out[PRF_IDX +: PRF_IDX] = ent_q[head_nx1].pdest;
        end

        disp[0] = issue[0] && dispatch_ok[0] && !flush;
        disp[1] = issue[1] && dispatch_ok[1] && !flush;
        n_disp  = {1'b0, disp[0]} + {1'b0, disp[1]};
        n_ret   = {1'b0, ret[0]} + {1'b0, ret[1]};

        for (int i = 0; i < ROB_SZ; i++) begin
            alloc0[i]   = disp[0] && (tail_q == ROB_IDX'(i));
            alloc1[i]   = disp[1] && (tail_w1 == ROB_IDX'(i));
            free_v[i]   = (ret[0] && (head_q == ROB_IDX'(i))) || (ret[1] && (head_nx1 == ROB_IDX'(i)));
            done_set[i] = ent_q[i].valid &&
                          ((complete[0] && (complete_rob_idx[0 +: ROB_IDX] == ROB_IDX'(i))) ||
                           (complete[1] && (complete_rob_idx[ROB_IDX +: ROB_IDX] == ROB_IDX'(i))));
            mp_set[i]   = ent_q[i].valid &&
                          ((complete[0] && complete_mispred[0] &&
                            (complete_rob_idx[0 +: ROB_IDX] == ROB_IDX'(i))) ||
                           (complete[1] && complete_mispred[1] &&
                            (complete_rob_idx[ROB_IDX +: ROB_IDX] == ROB_IDX'(i))));
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < ROB_SZ; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            head_q  <= head_q + ROB_IDX'(n_ret);
            tail_q  <= tail_q + ROB_IDX'(n_disp);
            count_q <= count_q + (ROB_IDX+1)'(n_disp) - (ROB_IDX+1)'(n_ret);
            for (int i = 0; i < ROB_SZ; i++) begin
                if (alloc0[i]) begin
                    ent_q[i] <= '{valid: 1'b1, done: 1'b0, mispred: 1'b0,
                                  dest: dest_idx_in[0 +: RAT_IDX],
                                  pdest: pdest_idx_in[0 +: PRF_IDX]};
                end else if (alloc1[i]) begin
                    ent_q[i] <= '{valid: 1'b1, done: 1'b0, mispred: 1'b0,
                                  dest: dest_idx_in[RAT_IDX +: RAT_IDX],
                                  pdest: pdest_idx_in[PRF_IDX +: PRF_IDX]};
                end else if (free_v[i]) begin
                    ent_q[i] <= '0;
                end else if (done_set[i]) begin
                    ent_q[i].done    <= 1'b1;
                    ent_q[i].mispred <= ent_q[i].mispred | mp_set[i];
                end
            end
        end
    end

endmodule
